// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : MIPS instruction-decode stage. Fetched {pc, inst} pairs enter a
//             small circular queue via a valid/ready handshake; the head entry
//             is decoded into a registered field bundle handed to execute.
//             Load-use hazards reported by execute stall the head; flush
//             empties the queue and invalidates the output register.
//  Ports    : clk, rst_n (sync, active-low), flush
//             in_valid/in_ready/in_inst/in_pc      - fetch side
//             ex_valid/ex_is_load/ex_wreg          - hazard info from execute
//             out_valid/out_ready/out_opcode/out_func/out_rs/out_rt/
//             out_wreg/out_imm/out_pc              - decoded bundle to execute
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int FIFO_DEPTH = 4,
    parameter int PC_W       = 32,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_func,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_wreg,
    output logic [31:0]       out_imm,
    output logic [PC_W-1:0]   out_pc
);

    localparam int                c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [REG_AW-1:0] c_link  = '1;

    logic [31:0]        r_inst_q [FIFO_DEPTH];
    logic [PC_W-1:0]    r_pc_q   [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [31:0]        w_head_inst;
    logic [PC_W-1:0]    w_head_pc;
    logic [5:0]         w_opcode;
    logic [REG_AW-1:0]  w_rs;
    logic [REG_AW-1:0]  w_rt;
    logic [REG_AW-1:0]  w_wreg;
    logic [31:0]        w_imm;
    logic               w_hazard;
    logic               w_adv;
    logic               w_push;
    logic               w_pop;

    // Full queue refuses even when a pop happens in the same cycle.
    assign in_ready    = rst_n && (r_count < c_depth);
    assign w_push      = in_valid && in_ready;

    assign w_head_inst = r_inst_q[r_rd_ptr];
    assign w_head_pc   = r_pc_q[r_rd_ptr];
    assign w_opcode    = w_head_inst[31:26];
    assign w_rs        = w_head_inst[25:21];
    assign w_rt        = w_head_inst[20:16];

    // Register 0 is never a real producer, so a load into it cannot stall.
    assign w_hazard = ex_valid && ex_is_load && (ex_wreg != '0) &&
                      ((ex_wreg == w_rs) || (ex_wreg == w_rt));

    assign w_adv = !out_valid || out_ready;
    assign w_pop = w_adv && (r_count != '0) && !w_hazard;

    always_comb begin
        w_wreg = w_rt;
        if (w_opcode == 6'h00) begin
            w_wreg = w_head_inst[15:11];
        end else if (w_opcode == 6'h03) begin
            w_wreg = c_link;
        end
    end

    always_comb begin
        w_imm = {{16{w_head_inst[15]}}, w_head_inst[15:0]};
        case (w_opcode)
            6'h0C, 6'h0D, 6'h0E: w_imm = {16'h0000, w_head_inst[15:0]};
            6'h0F:               w_imm = {w_head_inst[15:0], 16'h0000};
            default:             w_imm = {{16{w_head_inst[15]}}, w_head_inst[15:0]};
        endcase
    end

    // Storage needs no reset: only entries covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_inst_q[r_wr_ptr] <= in_inst;
            r_pc_q[r_wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_func   <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_wreg   <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_pop) begin
                out_valid  <= 1'b1;
                out_opcode <= w_opcode;
                out_func   <= w_head_inst[5:0];
                out_rs     <= w_rs;
                out_rt     <= w_rt;
                out_wreg   <= w_wreg;
                out_imm    <= w_imm;
                out_pc     <= w_head_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Self-checking bench for id_stage against a queue-based
//             behavioural model of the decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int FW    = 6 + 6 + 5 * 3 + 32 + PW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [PW-1:0] in_pc;
    logic          ex_valid;
    logic          ex_is_load;
    logic [4:0]    ex_wreg;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_opcode;
    logic [5:0]    out_func;
    logic [4:0]    out_rs;
    logic [4:0]    out_rt;
    logic [4:0]    out_wreg;
    logic [31:0]   out_imm;
    logic [PW-1:0] out_pc;
    logic [FW-1:0] dut_f;

    id_stage #(.FIFO_DEPTH(DEPTH), .PC_W(PW), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_func(out_func), .out_rs(out_rs),
        .out_rt(out_rt), .out_wreg(out_wreg), .out_imm(out_imm), .out_pc(out_pc)
    );

    assign dut_f = {out_opcode, out_func, out_rs, out_rt, out_wreg, out_imm, out_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: queue of {pc, inst}, plus the visible output bundle.
    logic [PW+31:0] mq [$];
    logic           m_ov;
    logic [FW-1:0]  m_f;
    logic           m_acc;

    function automatic logic [FW-1:0] ref_decode(input logic [PW+31:0] e);
        logic [31:0]   inst;
        logic [PW-1:0] pc;
        int unsigned   op;
        logic [4:0]    wreg;
        logic [31:0]   imm;
        int            sv;
        inst = e[31:0];
        pc   = e[PW+31:32];
        op   = int'(inst[31:26]);
        if (op == 0)      wreg = inst[15:11];
        else if (op == 3) wreg = 5'd31;
        else              wreg = inst[20:16];
        if (op >= 12 && op <= 14) begin
            imm = {16'h0000, inst[15:0]};
        end else if (op == 15) begin
            imm = 32'(inst[15:0]) * 32'd65536;
        end else begin
            sv  = int'($signed(inst[15:0]));
            imm = 32'(sv);
        end
        return {inst[31:26], inst[5:0], inst[25:21], inst[20:16], wreg, imm, pc};
    endfunction

    function automatic logic m_rdy();
        return rst_n && (mq.size() < DEPTH);
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic tick();
        logic           adv, hz, pop, push;
        logic [PW+31:0] head, ent;
        ent  = {in_pc, in_inst};
        push = rst_n && in_valid && (mq.size() < DEPTH);
        adv  = !m_ov || out_ready;
        hz   = 1'b0;
        if (mq.size() > 0) begin
            head = mq[0];
            hz = ex_valid && ex_is_load && (ex_wreg != 5'd0) &&
                 ((ex_wreg == head[25:21]) || (ex_wreg == head[20:16]));
        end
        pop   = adv && (mq.size() > 0) && !hz;
        m_acc = push && !flush;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_ov = 1'b0;
            m_f  = '0;
        end else if (flush) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            if (adv) begin
                if (pop) begin
                    m_f  = ref_decode(mq.pop_front());
                    m_ov = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
            if (push) mq.push_back(ent);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 3) tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_inst   = $urandom;
        in_pc     = $urandom;
        repeat (2) tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dut_f !== '0) begin
            n_bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b fields=%h, want 0/0/0",
                     in_ready, out_valid, dut_f);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] t_inst [5] = '{32'h00851020, 32'h3C01ABCD, 32'h3401FFFF,
                                    32'h2001FFFF, 32'h0C000010};
        logic [4:0]  t_wreg [5] = '{5'd2, 5'd1, 5'd1, 5'd1, 5'd31};
        logic [31:0] t_imm  [5] = '{32'h00001020, 32'hABCD0000, 32'h0000FFFF,
                                    32'hFFFFFFFF, 32'h00000010};
        drain();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = t_inst[i];
            in_pc    = 32'h100 + 32'(4 * i);
            tick();
            in_valid = 1'b0;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_wreg !== t_wreg[i] || out_imm !== t_imm[i] ||
                out_pc !== 32'h100 + 32'(4 * i) || dut_f !== m_f) begin
                n_bad++;
                $display("FAIL decode[%0d]: v=%b wreg=%0d imm=%h pc=%h, want v=1 wreg=%0d imm=%h pc=%h (model %h got %h)",
                         i, out_valid, out_wreg, out_imm, out_pc, t_wreg[i], t_imm[i],
                         32'h100 + 32'(4 * i), m_f, dut_f);
            end
        end
        n_cmp++;
        if (ref_decode({32'h100, t_inst[0]}) !== {6'h00, 6'h20, 5'd4, 5'd5, 5'd2, 32'h1020, 32'h100} ||
            dut_f === '0) begin
            n_bad++;
            $display("FAIL decode_add_fields: model or dut bundle not as expected, dut=%h", dut_f);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8);
            in_inst  = $urandom;
            in_pc    = 32'h800 + 32'(4 * i);
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 32'h800 + 32'(4 * (i - 1)) || dut_f !== m_f) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: v=%b pc=%h, want v=1 pc=%h",
                             i, out_valid, out_pc, 32'h800 + 32'(4 * (i - 1)));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] got [$];
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = $urandom;
            in_pc    = 32'h200 + 32'(4 * i);
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200) begin
            n_bad++;
            $display("FAIL full: in_ready=%b out_valid=%b out_pc=%h, want 0/1/200",
                     in_ready, out_valid, out_pc);
        end
        in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_pc !== 32'h200 || dut_f !== m_f) begin
            n_bad++;
            $display("FAIL full_hold: in_ready=%b out_pc=%h, want 0/200", in_ready, out_pc);
        end
        got.push_back(out_pc);
        out_ready = 1'b1;
        repeat (8) begin
            tick();
            if (out_valid === 1'b1) got.push_back(out_pc);
        end
        n_cmp++;
        if (got.size() != 5) begin
            n_bad++;
            $display("FAIL drain_count: got %0d items, want 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got[i] !== 32'h200 + 32'(4 * i)) begin
                    n_bad++;
                    $display("FAIL drain_order[%0d]: pc=%h want %h", i, got[i], 32'h200 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_load_use();
        drain();
        in_valid = 1'b1;
        in_inst  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
        in_pc    = 32'h600;
        tick();
        in_valid   = 1'b0;
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_wreg    = 5'd8;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL load_use_stall[%0d]: out_valid=%b want 0", i, out_valid);
            end
        end
        ex_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rs !== 5'd8 || out_pc !== 32'h600) begin
            n_bad++;
            $display("FAIL load_use_issue: v=%b rs=%0d pc=%h, want 1/8/600", out_valid, out_rs, out_pc);
        end
        ex_valid = 1'b1;
        ex_wreg  = 5'd0;
        in_valid = 1'b1;
        in_inst  = {6'h00, 5'd0, 5'd8, 5'd9, 5'd0, 6'h20};
        in_pc    = 32'h604;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h604) begin
            n_bad++;
            $display("FAIL load_use_r0: v=%b pc=%h, want 1/604", out_valid, out_pc);
        end
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
    endtask

    task automatic test_flush();
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = $urandom;
            in_pc    = 32'h700 + 32'(4 * i);
            tick();
        end
        flush = 1'b1;
        in_pc = 32'h400;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_empty[%0d]: out_valid=%b pc=%h, want 0", i, out_valid, out_pc);
            end
        end
        in_valid = 1'b1;
        in_inst  = $urandom;
        in_pc    = 32'h500;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
            n_bad++;
            $display("FAIL flush_refill: v=%b pc=%h, want 1/500", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] ops [10] = '{6'h00, 6'h03, 6'h0C, 6'h0D, 6'h0E,
                                 6'h0F, 6'h08, 6'h23, 6'h2B, 6'h04};
        int acc = 0;
        int hs  = 0;
        int cyc = 0;
        drain();
        while ((acc < 20 || mq.size() > 0 || m_ov) && cyc < 600) begin
            in_valid   = (acc < 20) && ($urandom_range(0, 3) != 0);
            in_inst    = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 16'($urandom)};
            in_pc      = 32'h1000 + 32'(4 * acc);
            out_ready  = ($urandom_range(0, 2) != 0);
            ex_valid   = ($urandom_range(0, 1) != 0);
            ex_is_load = ($urandom_range(0, 1) != 0);
            ex_wreg    = 5'($urandom_range(0, 7));
            if (out_valid === 1'b1 && out_ready) hs++;
            tick();
            if (m_acc) acc++;
            cyc++;
            n_cmp++;
            if (out_valid !== m_ov || (m_ov && dut_f !== m_f) || in_ready !== m_rdy()) begin
                n_bad++;
                $display("FAIL wrap cyc %0d: v=%b rdy=%b f=%h, want v=%b rdy=%b f=%h",
                         cyc, out_valid, in_ready, dut_f, m_ov, m_rdy(), m_f);
            end
        end
        in_valid = 1'b0;
        ex_valid = 1'b0;
        n_cmp++;
        if (cyc >= 600 || hs != 20) begin
            n_bad++;
            $display("FAIL wrap_total: handshakes=%0d cycles=%0d, want 20 within 600", hs, cyc);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_inst    = '0;
        in_pc      = '0;
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_wreg    = '0;
        out_ready  = 1'b1;
        m_ov       = 1'b0;
        m_f        = '0;
        m_acc      = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_load_use();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
